// File: rtl/load_ext_unit.sv
// Load-data extraction unit: aligned RAM read, byte/half/word select and zero/sign extension.
// Define LOAD_SPLIT_EN to service word-crossing loads as two aligned reads merged into one result.
module load_ext_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_op,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] rsp_addr
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

`ifdef LOAD_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    localparam logic [2:0] OP_W   = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LH  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RD0, S_RD1, S_RSP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   word0_q, word0_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          err_q, err_d;
    logic                rd_en_s;
    logic [OFF_W-1:0]    req_off_s;
    logic [OFF_W-1:0]    cur_off_s;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [OFF_W:0] size_of(input logic [2:0] op);
        case (op)
            OP_LBU, OP_LB: return (OFF_W+1)'(1);
            OP_LHU, OP_LH: return (OFF_W+1)'(2);
            default:       return (OFF_W+1)'(LANES);
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [OFF_W-1:0] off);
        case (op)
            OP_LHU, OP_LH: return off[0];
            OP_W:          return (off != '0);
            default:       return 1'b0;
        endcase
    endfunction

    // True when the access runs past the end of the addressed word.
    function automatic logic crosses(input logic [2:0] op, input logic [OFF_W-1:0] off);
        return (({1'b0, off} + size_of(op)) > (OFF_W+1)'(LANES));
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [2:0] op, input logic [OFF_W-1:0] off,
                                                 input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
        logic [DATA_W-1:0] sh;
        sh = DATA_W'({hi, lo} >> {off, 3'b000});
        case (op)
            OP_LBU:  return {{(DATA_W-8){1'b0}}, sh[7:0]};
            OP_LB:   return {{(DATA_W-8){sh[7]}}, sh[7:0]};
            OP_LHU:  return {{(DATA_W-16){1'b0}}, sh[15:0]};
            OP_LH:   return {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign req_off_s = req_addr[OFF_W-1:0];
    assign cur_off_s = addr_q[OFF_W-1:0];
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign rsp_addr  = addr_q;
    assign mem_rd_en = rd_en_s & ~reset;

    // Next-state, RAM strobe and response result selection.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_d     = op_q;
        word0_d  = word0_q;
        data_d   = data_q;
        err_d    = err_q;
        rd_en_s  = 1'b0;
        mem_addr = align(addr_q);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    op_d   = req_op;
                    if (req_op > OP_LH) begin
                        err_d   = 2'b10;
                        data_d  = '0;
                        state_d = S_RSP;
                    end else if (misaligned(req_op, req_off_s) && !SPLIT_EN) begin
                        err_d   = 2'b01;
                        data_d  = '0;
                        state_d = S_RSP;
                    end else begin
                        rd_en_s  = 1'b1;
                        mem_addr = align(req_addr);
                        state_d  = S_RD0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD0: begin
                if (SPLIT_EN && crosses(op_q, cur_off_s)) begin
                    word0_d  = mem_rdata;
                    rd_en_s  = 1'b1;
                    mem_addr = align(addr_q) + ADDR_W'(LANES);
                    state_d  = S_RD1;
                end else begin
                    data_d  = extract(op_q, cur_off_s, {DATA_W{1'b0}}, mem_rdata);
                    err_d   = 2'b00;
                    state_d = S_RSP;
                end
            end
            S_RD1: begin
                data_d  = extract(op_q, cur_off_s, mem_rdata, word0_q);
                err_d   = 2'b00;
                state_d = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RSP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= 3'd0;
            word0_q <= '0;
            data_q  <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            word0_q <= word0_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_ext_unit.sv
// Bench for load_ext_unit (DATA_W=32): directed table, split/reset sequences, randomized loads vs byte-level model.
module tb_load_ext_unit;

`ifdef LOAD_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_addr;

    logic [31:0] ram [16];
    int unsigned rd_cnt  = 0;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] prev_rd = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_ext_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_addr(rsp_addr)
    );

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= ram[mem_addr[5:2]];
            rd_cnt    <= rd_cnt + 1;
            prev_rd   <= last_rd;
            last_rd   <= mem_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = ram[a[5:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: gather the addressed bytes little-endian, then extend.
    task automatic ref_load(input logic [31:0] a, input logic [2:0] op,
                            output logic [31:0] d, output logic [1:0] e, output int lat, output int nrd);
        int size;
        bit mis;
        logic [31:0] v;
        d = 32'h0;
        e = 2'b00;
        if (op > 3'd4) begin
            e = 2'b10; lat = 1; nrd = 0;
        end else begin
            size = (op == 3'd0) ? 4 : ((op <= 3'd2) ? 1 : 2);
            mis  = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
            if (mis && !SPLIT) begin
                e = 2'b01; lat = 1; nrd = 0;
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(byte_at(a + 32'(i))) << (8 * i));
                if (op == 3'd2 && v[7])  v = v | 32'hFFFF_FF00;
                if (op == 3'd4 && v[15]) v = v | 32'hFFFF_0000;
                d   = v;
                nrd = (int'(a[1:0]) + size > 4) ? 2 : 1;
                lat = nrd + 1;
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] ed, input logic [1:0] ee, input int el, input int enr,
                           input int hold);
        int lat;
        int unsigned rd0;
        @(negedge clk);
        chk($sformatf("%s req_ready_idle", tag), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_op    = op;
        #1;
        chk($sformatf("%s rd_en_T", tag), 32'(mem_rd_en), 32'(enr > 0));
        if (enr > 0) chk($sformatf("%s mem_addr_T", tag), mem_addr, a & 32'hFFFF_FFFC);
        rd0 = rd_cnt;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 8);
        chk($sformatf("%s rsp_valid", tag), 32'(rsp_valid), 32'd1);
        chk($sformatf("%s latency", tag), 32'(lat), 32'(el));
        chk($sformatf("%s data", tag), rsp_data, ed);
        chk($sformatf("%s err", tag), 32'(rsp_err), 32'(ee));
        chk($sformatf("%s addr", tag), rsp_addr, a);
        chk($sformatf("%s reads", tag), 32'(rd_cnt - rd0), 32'(enr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s hold_valid", tag), 32'(rsp_valid), 32'd1);
            chk($sformatf("%s hold_data", tag), rsp_data, ed);
            chk($sformatf("%s hold_err", tag), 32'(rsp_err), 32'(ee));
            chk($sformatf("%s hold_addr", tag), rsp_addr, a);
            chk($sformatf("%s hold_req_ready", tag), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("%s drop_valid", tag), 32'(rsp_valid), 32'd0);
        chk($sformatf("%s back_idle", tag), 32'(req_ready), 32'd1);
    endtask

    // Start a load, assert reset after n_neg cycles, verify it is abandoned.
    task automatic reset_mid(input string tag, input logic [31:0] a, input logic [2:0] op, input int n_neg);
        int unsigned rd0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_op    = op;
        @(posedge clk);
        for (int i = 0; i < n_neg; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        reset = 1'b1;
        rd0 = rd_cnt;
        #1;
        chk($sformatf("%s rd_en_in_reset", tag), 32'(mem_rd_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk($sformatf("%s ready", tag), 32'(req_ready), 32'd1);
        chk($sformatf("%s data", tag), rsp_data, 32'h0);
        chk($sformatf("%s err", tag), 32'(rsp_err), 32'd0);
        chk($sformatf("%s addr", tag), rsp_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s no_rsp", tag), 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("%s no_reads", tag), 32'(rd_cnt - rd0), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0] a, ed;
        logic [2:0]  op;
        logic [1:0]  ee;
        int          el, enr;

        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[0] = 32'h807F_12FF;

        vt[0]  = '{32'h0, 3'd2, 32'hFFFF_FFFF, 2'b00, 2};
        vt[1]  = '{32'h2, 3'd3, 32'h0000_807F, 2'b00, 2};
        vt[2]  = '{32'h2, 3'd4, 32'hFFFF_807F, 2'b00, 2};
        vt[3]  = '{32'h0, 3'd1, 32'h0000_00FF, 2'b00, 2};
        vt[4]  = '{32'h1, 3'd2, 32'h0000_0012, 2'b00, 2};
        vt[5]  = '{32'h3, 3'd2, 32'hFFFF_FF80, 2'b00, 2};
        vt[6]  = '{32'h0, 3'd0, 32'h807F_12FF, 2'b00, 2};
        vt[7]  = '{32'h0, 3'd4, 32'h0000_12FF, 2'b00, 2};
        vt[8]  = '{32'h5, 3'd7, 32'h0000_0000, 2'b10, 1};
        vt[12] = '{32'h0, 3'd5, 32'h0000_0000, 2'b10, 1};
`ifdef LOAD_SPLIT_EN
        vt[9]  = '{32'h5, 3'd0, 32'h0000_0000, 2'b00, 3};
        vt[10] = '{32'h1, 3'd3, 32'h0000_7F12, 2'b00, 2};
        vt[11] = '{32'h3, 3'd3, 32'h0000_0080, 2'b00, 3};
`else
        vt[9]  = '{32'h5, 3'd0, 32'h0000_0000, 2'b01, 1};
        vt[10] = '{32'h1, 3'd3, 32'h0000_0000, 2'b01, 1};
        vt[11] = '{32'h3, 3'd3, 32'h0000_0000, 2'b01, 1};
`endif

        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        req_op    = 3'd0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset rd_en_gated", 32'(mem_rd_en), 32'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", rsp_data, 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_addr", rsp_addr, 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_load($sformatf("vec%0d", i), vt[i].addr, vt[i].op, vt[i].data, vt[i].err,
                    vt[i].lat, vt[i].lat - 1, (i == 0) ? 5 : 0);
        end

        reset_mid("rst_rd0", 32'h0, 3'd2, 1);

`ifdef LOAD_SPLIT_EN
        ram[0] = 32'h4433_2211;
        ram[1] = 32'h8877_6655;
        do_load("split_lh3", 32'h3, 3'd4, 32'h0000_5544, 2'b00, 3, 2, 0);
        chk("split_lh3 first_rd", prev_rd, 32'h0);
        chk("split_lh3 second_rd", last_rd, 32'h4);
        do_load("split_lw1", 32'h1, 3'd0, 32'h5544_3322, 2'b00, 3, 2, 2);
        reset_mid("rst_rd1", 32'h3, 3'd4, 2);
        ram[15] = 32'hA1B2_C3D4;
        do_load("split_wrap", 32'hFFFF_FFFE, 3'd0, 32'h2211_A1B2, 2'b00, 3, 2, 0);
        chk("split_wrap second_rd", last_rd, 32'h0);
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) ram[$urandom_range(0, 15)] = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                          a = 32'($urandom_range(0, 63));
            op = 3'($urandom_range(0, 7));
            ref_load(a, op, ed, ee, el, enr);
            do_load($sformatf("rnd%0d", n), a, op, ed, ee, el, enr, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
